sd_line_tx: RTL and testbench

- Transmitter for the two-wire strobe/data (S/D) line protocol; peer of the existing Mealy line receiver (outputs R/Y).
- Accepts a parallel word via a valid/ready handshake and serialises it MSB-first as S/D symbols.
- Each symbol is shaped so the receiver asserts R for one cycle with Y equal to the transmitted bit.
- Sits between a local data source and the S/D pins, in the same clock domain as the receiver.

---
 rtl/sd_line_pkg.sv | 27 ++
 rtl/sd_symbol_gen.sv | 94 +++++++++
 rtl/sd_line_tx.sv | 78 +++++++
 tb/tb_sd_line_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_line_pkg.sv
// ============================================================================
// Module   : sd_line_pkg
// Purpose  : Shared types and symbol timing for the S/D line transmitter/receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_line_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP1   = 2'd2,
    ST_GAP2   = 2'd3
  } sd_state_e;

  localparam int unsigned GAP_CYCLES_0 = 1;
  localparam int unsigned GAP_CYCLES_1 = 2;

  // Number of S=0 cycles that close a symbol carrying bit b.
  function automatic int unsigned gap_len(input logic b);
    return b ? GAP_CYCLES_1 : GAP_CYCLES_0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_symbol_gen.sv
// ============================================================================
// Module   : sd_symbol_gen
// Purpose  : Shapes one bit into an S/D symbol (strobe, then one or two gaps).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_symbol_gen
  import sd_line_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_in,
  output logic s,
  output logic d,
  output logic sym_end,
  output logic active
);

  localparam int HCW = $clog2(HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

  sd_state_e      r_state;
  sd_state_e      w_state_next;
  logic           r_bit;
  logic [HCW-1:0] r_hold_cnt;
  logic           w_last_gap1;
  logic           w_take;

  assign w_last_gap1 = (gap_len(r_bit) == 32'd1);
  // A new symbol may only begin from idle or on the closing cycle of the current one.
  assign w_take      = start & ((r_state == ST_IDLE) | sym_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit      <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_bit      <= bit_in;
        r_hold_cnt <= '0;
      end else if (r_state == ST_STROBE) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_take) w_state_next = ST_STROBE;
      ST_STROBE: if (r_hold_cnt == HOLD_LAST) w_state_next = ST_GAP1;
      ST_GAP1: begin
        if (!w_last_gap1) w_state_next = ST_GAP2;
        else              w_state_next = w_take ? ST_STROBE : ST_IDLE;
      end
      ST_GAP2:   w_state_next = w_take ? ST_STROBE : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s       = 1'b0;
    d       = 1'b0;
    sym_end = 1'b0;
    active  = 1'b0;
    case (r_state)
      ST_STROBE: begin
        s      = 1'b1;
        d      = r_bit;
        active = 1'b1;
      end
      ST_GAP1: begin
        d       = r_bit;
        active  = 1'b1;
        sym_end = w_last_gap1;
      end
      ST_GAP2: begin
        d       = r_bit;
        active  = 1'b1;
        sym_end = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sd_line_tx.sv
// ============================================================================
// Module   : sd_line_tx
// Purpose  : S/D line transmitter: valid/ready word intake, MSB-first serialiser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_line_tx
  import sd_line_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 1
) (
  input  logic             C,
  input  logic             aR,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             S,
  output logic             D,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] BITS_FULL = BCW'(WIDTH);
  localparam logic [BCW-1:0] BITS_LAST = BCW'(1);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [BCW-1:0]   r_bit_cnt;
  logic             w_active;
  logic             w_sym_end;
  logic             w_accept;
  logic             w_more;
  logic             w_start;
  logic             w_bit;

  assign tx_ready     = ~w_active;
  assign w_accept     = tx_valid & tx_ready;
  assign w_more       = w_sym_end & (r_bit_cnt != BITS_LAST);
  assign w_start      = w_accept | w_more;
  assign w_shift_next = r_shift << 1;
  // The generator latches the bit on start, so feed it the bit that will be current next cycle.
  assign w_bit        = w_accept ? tx_data[WIDTH-1] : w_shift_next[WIDTH-1];

  always_ff @(posedge C) begin
    if (aR) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= tx_data;
      r_bit_cnt <= BITS_FULL;
    end else if (w_sym_end) begin
      r_shift   <= w_shift_next;
      r_bit_cnt <= r_bit_cnt - 1'b1;
    end
  end

  sd_symbol_gen #(
    .HOLD (HOLD)
  ) u_symbol_gen (
    .clk     (C),
    .rst     (aR),
    .start   (w_start),
    .bit_in  (w_bit),
    .s       (S),
    .d       (D),
    .sym_end (w_sym_end),
    .active  (w_active)
  );

  assign busy = w_active;
  assign done = w_sym_end & (r_bit_cnt == BITS_LAST);

endmodule

`default_nettype wire

// File: tb/tb_sd_line_tx.sv
// ============================================================================
// Module   : tb_sd_line_tx
// Purpose  : Directed bench for sd_line_tx (HOLD=1 and HOLD=3) with receiver model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sd_line_tx;

  logic       C = 1'b0;
  logic       aR;
  logic [1:0] tx_valid_v;
  logic [7:0] tx_data_v [2];
  logic       ready0, ready1, s0, s1, d0, d1, busy0, busy1, done0, done1;
  logic [1:0] ready_v, s_v, d_v, busy_v, done_v;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [1:0] trace [0:255];
  logic [1:0] rx_st [2];
  logic [7:0] rx_word [2];
  int         rx_cnt [2] = '{0, 0};

  always #5 C = ~C;

  assign ready_v = {ready1, ready0};
  assign s_v     = {s1, s0};
  assign d_v     = {d1, d0};
  assign busy_v  = {busy1, busy0};
  assign done_v  = {done1, done0};

  sd_line_tx #(.WIDTH(8), .HOLD(1)) u_dut (
    .C(C), .aR(aR), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(ready0), .S(s0), .D(d0), .busy(busy0), .done(done0)
  );

  sd_line_tx #(.WIDTH(8), .HOLD(3)) u_dut3 (
    .C(C), .aR(aR), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
    .tx_ready(ready1), .S(s1), .D(d1), .busy(busy1), .done(done1)
  );

  // Mealy receiver model: 0=wait strobe, 1=strobe seen, 2=intermediate (bit 1 pending)
  always @(posedge C) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (aR) begin
        rx_st[ch] <= 2'd0;
      end else begin
        case (rx_st[ch])
          2'd0: if (s_v[ch]) rx_st[ch] <= 2'd1;
          2'd1: begin
            if (!s_v[ch]) begin
              if (d_v[ch]) begin
                rx_st[ch] <= 2'd2;
              end else begin
                rx_word[ch] <= {rx_word[ch][6:0], 1'b0};
                rx_cnt[ch]  <= rx_cnt[ch] + 1;
                rx_st[ch]   <= 2'd0;
              end
            end
          end
          default: begin
            rx_word[ch] <= {rx_word[ch][6:0], 1'b1};
            rx_cnt[ch]  <= rx_cnt[ch] + 1;
            rx_st[ch]   <= s_v[ch] ? 2'd1 : 2'd0;
          end
        endcase
      end
    end
  end

  // Hands a word over and records (S,D) per busy cycle; optionally pokes tx_valid mid-word.
  task automatic send_word(input int ch, input logic [7:0] data, input bit inject,
                           output int cycles, output int done_at, output int done_pulses);
    int guard;
    cycles = 0; done_at = 0; done_pulses = 0; guard = 0;
    @(negedge C);
    while (!ready_v[ch] && guard < 100) begin
      @(negedge C);
      guard++;
    end
    tx_data_v[ch]  = data;
    tx_valid_v[ch] = 1'b1;
    @(negedge C);
    tx_valid_v[ch] = 1'b0;
    guard = 0;
    while (busy_v[ch] && guard < 200) begin
      cycles++;
      trace[cycles] = {s_v[ch], d_v[ch]};
      if (done_v[ch]) begin
        done_at = cycles;
        done_pulses++;
      end
      if (inject && cycles == 3) begin
        tx_valid_v[ch] = 1'b1;
        tx_data_v[ch]  = 8'hC3;
      end
      if (inject && cycles == 12) tx_valid_v[ch] = 1'b0;
      @(negedge C);
      guard++;
    end
  endtask

  task automatic test_reset();
    aR = 1'b1;
    tx_valid_v = 2'b00;
    tx_data_v[0] = 8'h00;
    tx_data_v[1] = 8'h00;
    repeat (2) @(posedge C);
    @(negedge C);
    for (int ch = 0; ch < 2; ch++) begin
      n_cmp++;
      if ({s_v[ch], d_v[ch], busy_v[ch], done_v[ch], ready_v[ch]} !== 5'b00001) begin
        n_fail++;
        $display("FAIL reset_outputs ch%0d: got {S,D,busy,done,ready}=%b expected 00001", ch,
                 {s_v[ch], d_v[ch], busy_v[ch], done_v[ch], ready_v[ch]});
      end
    end
    aR = 1'b0;
  endtask

  task automatic test_a5();
    int cyc, dat, dp, rc;
    logic [39:0] exp_a5;
    exp_a5 = 40'b11_01_01_10_00_11_01_01_10_00_10_00_11_01_01_10_00_11_01_01;
    rc = rx_cnt[0];
    send_word(0, 8'hA5, 1'b0, cyc, dat, dp);
    n_cmp++;
    if (cyc !== 20) begin n_fail++; $display("FAIL a5_cycles: got %0d expected 20", cyc); end
    n_cmp++;
    if (dat !== 20) begin n_fail++; $display("FAIL a5_done_cycle: got %0d expected 20", dat); end
    n_cmp++;
    if (dp !== 1) begin n_fail++; $display("FAIL a5_done_pulses: got %0d expected 1", dp); end
    for (int k = 1; k <= 20; k++) begin
      n_cmp++;
      if (trace[k] !== exp_a5[41-2*k -: 2]) begin
        n_fail++;
        $display("FAIL a5_sd cycle %0d: got %b expected %b", k, trace[k], exp_a5[41-2*k -: 2]);
      end
    end
    n_cmp++;
    if (rx_cnt[0] - rc !== 8) begin n_fail++; $display("FAIL a5_rx_count: got %0d expected 8", rx_cnt[0] - rc); end
    n_cmp++;
    if (rx_word[0] !== 8'hA5) begin n_fail++; $display("FAIL a5_rx_word: got %h expected a5", rx_word[0]); end
  endtask

  task automatic test_back_to_back();
    int cyc, dat, guard;
    logic rdy_at_done;
    @(negedge C);
    tx_data_v[0]  = 8'h00;
    tx_valid_v[0] = 1'b1;
    @(negedge C);
    tx_data_v[0] = 8'hFF;
    cyc = 0; dat = 0; guard = 0; rdy_at_done = 1'b1;
    while (busy_v[0] && guard < 200) begin
      cyc++;
      if (done_v[0]) begin dat = cyc; rdy_at_done = ready_v[0]; end
      @(negedge C);
      guard++;
    end
    n_cmp++;
    if (cyc !== 16) begin n_fail++; $display("FAIL b2b_zero_cycles: got %0d expected 16", cyc); end
    n_cmp++;
    if (dat !== 16) begin n_fail++; $display("FAIL b2b_zero_done: got %0d expected 16", dat); end
    n_cmp++;
    if ({rdy_at_done, ready_v[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_ready_after_done: got {at_done,after}=%b expected 01", {rdy_at_done, ready_v[0]});
    end
    n_cmp++;
    if (rx_word[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_rx_zero: got %h expected 00", rx_word[0]); end
    @(negedge C);
    tx_valid_v[0] = 1'b0;
    n_cmp++;
    if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ff_accepted: got busy=%b expected 1", busy_v[0]); end
    cyc = 0; dat = 0; guard = 0;
    while (busy_v[0] && guard < 200) begin
      cyc++;
      if (done_v[0]) dat = cyc;
      @(negedge C);
      guard++;
    end
    n_cmp++;
    if (cyc !== 24) begin n_fail++; $display("FAIL b2b_ff_cycles: got %0d expected 24", cyc); end
    n_cmp++;
    if (dat !== 24) begin n_fail++; $display("FAIL b2b_ff_done: got %0d expected 24", dat); end
    n_cmp++;
    if (rx_word[0] !== 8'hFF) begin n_fail++; $display("FAIL b2b_rx_ff: got %h expected ff", rx_word[0]); end
  endtask

  task automatic test_hold3();
    int cyc, dat, dp, rc;
    logic [11:0] exp_head;
    exp_head = 12'b11_11_11_01_01_10;
    rc = rx_cnt[1];
    send_word(1, 8'h80, 1'b0, cyc, dat, dp);
    n_cmp++;
    if (cyc !== 33) begin n_fail++; $display("FAIL hold3_cycles: got %0d expected 33", cyc); end
    n_cmp++;
    if (dat !== 33) begin n_fail++; $display("FAIL hold3_done_cycle: got %0d expected 33", dat); end
    for (int k = 1; k <= 6; k++) begin
      n_cmp++;
      if (trace[k] !== exp_head[13-2*k -: 2]) begin
        n_fail++;
        $display("FAIL hold3_sd cycle %0d: got %b expected %b", k, trace[k], exp_head[13-2*k -: 2]);
      end
    end
    n_cmp++;
    if (rx_cnt[1] - rc !== 8) begin n_fail++; $display("FAIL hold3_rx_count: got %0d expected 8", rx_cnt[1] - rc); end
    n_cmp++;
    if (rx_word[1] !== 8'h80) begin n_fail++; $display("FAIL hold3_rx_word: got %h expected 80", rx_word[1]); end
  endtask

  task automatic test_ignore_busy();
    int cyc, dat, dp;
    send_word(0, 8'h5A, 1'b1, cyc, dat, dp);
    n_cmp++;
    if (cyc !== 20) begin n_fail++; $display("FAIL ignore_cycles: got %0d expected 20", cyc); end
    n_cmp++;
    if (dp !== 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d expected 1", dp); end
    n_cmp++;
    if (rx_word[0] !== 8'h5A) begin n_fail++; $display("FAIL ignore_rx_word: got %h expected 5a", rx_word[0]); end
    repeat (2) @(negedge C);
    n_cmp++;
    if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue: got busy=%b expected 0", busy_v[0]); end
  endtask

  task automatic test_reset_mid();
    int cyc, dat, dp, rc;
    tx_data_v[0]  = 8'hFF;
    tx_valid_v[0] = 1'b1;
    @(negedge C);
    tx_valid_v[0] = 1'b0;
    cyc = 1;
    while (cyc < 7) begin
      @(negedge C);
      cyc++;
    end
    n_cmp++;
    if ({busy_v[0], s_v[0], d_v[0]} !== 3'b111) begin
      n_fail++;
      $display("FAIL midrst_bit3_strobe: got {busy,S,D}=%b expected 111", {busy_v[0], s_v[0], d_v[0]});
    end
    aR = 1'b1;
    @(negedge C);
    n_cmp++;
    if ({s_v[0], d_v[0], ready_v[0], busy_v[0], done_v[0]} !== 5'b00100) begin
      n_fail++;
      $display("FAIL midrst_idle: got {S,D,ready,busy,done}=%b expected 00100",
               {s_v[0], d_v[0], ready_v[0], busy_v[0], done_v[0]});
    end
    aR = 1'b0;
    rc = rx_cnt[0];
    send_word(0, 8'h3C, 1'b0, cyc, dat, dp);
    n_cmp++;
    if (cyc !== 20) begin n_fail++; $display("FAIL midrst_3c_cycles: got %0d expected 20", cyc); end
    n_cmp++;
    if (rx_cnt[0] - rc !== 8) begin n_fail++; $display("FAIL midrst_rx_count: got %0d expected 8", rx_cnt[0] - rc); end
    n_cmp++;
    if (rx_word[0] !== 8'h3C) begin n_fail++; $display("FAIL midrst_rx_word: got %h expected 3c", rx_word[0]); end
  endtask

  initial begin
    aR = 1'b1;
    tx_valid_v = 2'b00;
    tx_data_v[0] = 8'h00;
    tx_data_v[1] = 8'h00;
    test_reset();
    test_a5();
    test_back_to_back();
    test_hold3();
    test_ignore_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
